// File: rtl/keypad_scanner_pkg.sv
// Shared keypad definitions: FSM state encodings, key-code constants, decode helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package keypad_scanner_pkg;

  // FSM state encodings, kept as plain 2-bit constants so wavegen-side tools can reuse them.
  localparam logic [1:0] ST_SCAN     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_HELD     = 2'd2;
  localparam logic [1:0] ST_RELEASE  = 2'd3;

  // Code format: [7:4] one-hot row, [3:0] one-hot column; all ones means silence.
  localparam logic [7:0] KEY_NONE    = 8'hFF;

  // Note-code anchors shared with wavegen.
  localparam logic [7:0] NOTE_C      = 8'h11;  // row0 / col0
  localparam logic [7:0] NOTE_D      = 8'h12;  // row0 / col1
  localparam logic [7:0] NOTE_E      = 8'h14;  // row0 / col2
  localparam logic [7:0] NOTE_F      = 8'h18;  // row0 / col3
  localparam logic [7:0] NOTE_HIGH_C = 8'h28;  // row1 / col3

  // True when exactly one active-low row line is pulled low.
  function automatic logic single_low(input logic [3:0] rows);
    logic [3:0] act;
    act = ~rows;
    return (act != 4'd0) && ((act & (act - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [3:0] col_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Decoded key event bundle between keypad_scanner (master) and its consumer (slave).
// Latency: n/a (wires only).
// Backpressure: none; the consumer must sample every pulse.
// Signals: key_code[7:0] debounced code, key_valid level, key_press / key_release 1-clk pulses.
interface keypad_scanner_if;
  import keypad_scanner_pkg::*;

  logic [7:0] key_code;
  logic       key_valid;
  logic       key_press;
  logic       key_release;

  modport master (output key_code, output key_valid, output key_press, output key_release);
  modport slave  (input  key_code, input  key_valid, input  key_press, input  key_release);

endinterface

// File: rtl/keypad_scanner_scan_tick.sv
// Free-running divider producing a one-clk tick every DIV clocks (column dwell period).
// Latency: first tick DIV clocks after reset release, then every DIV clocks.
// Backpressure: none; never stalls in any state.
// Ports: clk, rst (async active-low), tick (high while the divider sits at DIV-1).
module scan_tick #(
  parameter int DIV = 50_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int W = $clog2(DIV);

  logic [W-1:0] div_q, div_d;

  assign tick  = (div_q == W'(DIV - 1));
  assign div_d = tick ? '0 : div_q + W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) div_q <= '0;
    else      div_q <= div_d;
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner with debounce; drives decoded key codes straight into wavegen.
// Latency: outputs update 1 clk after the deciding tick; press accepted within 4+DEBOUNCE_TICKS ticks.
// Backpressure: none; pulses are single-clk and must be sampled by the consumer.
// Ports: clk, rst (async active-low), row_in[3:0] (async, active-low), col_out[3:0] (active-low),
//        key_if (master): key_code, key_valid, key_press, key_release.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int CLK_HZ         = 50_000_000,
  parameter int SCAN_HZ        = 1_000,
  parameter int DEBOUNCE_TICKS = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              row_in,
  output logic [3:0]              col_out,
  keypad_scanner_if.master        key_if
);
  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int CW  = $clog2(DEBOUNCE_TICKS + 1);
  // Count value on the tick whose sample completes the debounce window.
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);

  logic       tick;
  logic [3:0] sync1_q, rs_q;
  logic [1:0] state_q, state_d;
  logic [1:0] col_idx_q, col_idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] cand_row_q, cand_row_d;
  logic [1:0] cand_col_q, cand_col_d;
  logic [7:0] code_q, code_d;
  logic       valid_q, valid_d;
  logic       press_q, press_d;
  logic       release_q, release_d;

  scan_tick #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Two-flop synchroniser; idles high (no key) out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 4'hF;
      rs_q    <= 4'hF;
    end else begin
      sync1_q <= row_in;
      rs_q    <= sync1_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    col_idx_d  = col_idx_q;
    cnt_d      = cnt_q;
    cand_row_d = cand_row_q;
    cand_col_d = cand_col_q;
    code_d     = code_q;
    valid_d    = valid_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    if (tick) begin
      case (state_q)
        ST_SCAN: begin
          if (single_low(rs_q)) begin
            // col_idx stays put so the candidate column keeps being driven.
            cand_row_d = ~rs_q;
            cand_col_d = col_idx_q;
            cnt_d      = CW'(1);
            if (DEBOUNCE_TICKS > 1) begin
              state_d = ST_DEBOUNCE;
            end else begin
              state_d = ST_HELD;
              code_d  = {~rs_q, col_onehot(col_idx_q)};
              valid_d = 1'b1;
              press_d = 1'b1;
            end
          end else begin
            // Idle or ghosted (several rows low): keep scanning.
            col_idx_d = col_idx_q + 2'd1;
          end
        end
        ST_DEBOUNCE: begin
          if (rs_q == ~cand_row_q) begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) begin
              state_d = ST_HELD;
              code_d  = {cand_row_q, col_onehot(cand_col_q)};
              valid_d = 1'b1;
              press_d = 1'b1;
            end
          end else begin
            state_d   = ST_SCAN;
            col_idx_d = col_idx_q + 2'd1;
          end
        end
        ST_HELD: begin
          if (rs_q != ~cand_row_q) begin
            // A one-sample window means the first all-high sample already releases.
            if (DEBOUNCE_TICKS == 1 && rs_q == 4'hF) begin
              state_d   = ST_SCAN;
              col_idx_d = col_idx_q + 2'd1;
              code_d    = KEY_NONE;
              valid_d   = 1'b0;
              release_d = 1'b1;
            end else begin
              state_d = ST_RELEASE;
              cnt_d   = CW'(1);
            end
          end
        end
        default: begin  // ST_RELEASE
          if (rs_q == 4'hF) begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) begin
              state_d   = ST_SCAN;
              col_idx_d = col_idx_q + 2'd1;
              code_d    = KEY_NONE;
              valid_d   = 1'b0;
              release_d = 1'b1;
            end
          end else if (rs_q == ~cand_row_q) begin
            state_d = ST_HELD;
          end else begin
            // Another key in the same column: restart the release window.
            cnt_d = CW'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_SCAN;
      col_idx_q  <= 2'd0;
      cnt_q      <= '0;
      cand_row_q <= 4'd0;
      cand_col_q <= 2'd0;
      code_q     <= KEY_NONE;
      valid_q    <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_idx_q  <= col_idx_d;
      cnt_q      <= cnt_d;
      cand_row_q <= cand_row_d;
      cand_col_q <= cand_col_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      press_q    <= press_d;
      release_q  <= release_d;
    end
  end

  assign col_out            = ~col_onehot(col_idx_q);
  assign key_if.key_code    = code_q;
  assign key_if.key_valid   = valid_q;
  assign key_if.key_press   = press_q;
  assign key_if.key_release = release_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a physical keypad model feeds row_in from col_out,
// stimulus pushes expected press/release events, a monitor pops them as pulses appear.
module tb_keypad_scanner;
  localparam int DIV      = 10;
  localparam int DT       = 3;
  localparam int HOLD     = (4 + DT + 1) * DIV + 5;
  localparam int REL_WAIT = (DT + 2) * DIV + 5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [15:0] keys = 16'd0;  // bit r*4+c = key at row r, column c is down

  int total = 0;
  int bad   = 0;
  logic [8:0] exp_q[$];       // {is_press, key_code}
  logic [8:0] mon_got, mon_want;

  keypad_scanner_if kif();

  keypad_scanner #(
    .CLK_HZ         (1000),
    .SCAN_HZ        (100),
    .DEBOUNCE_TICKS (DT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .row_in  (row_in),
    .col_out (col_out),
    .key_if  (kif)
  );

  always #5 clk = ~clk;

  // Passive matrix: a row reads low when a pressed key connects it to a driven-low column.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] code_of(input int k);
    logic [3:0] one;
    one = 4'b0001;
    return {one << (k / 4), one << (k % 4)};
  endfunction

  function automatic logic [3:0] col_drive(input int c);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << c);
  endfunction

  // Monitor: every pulse must match the oldest outstanding expected event.
  always @(negedge clk) begin
    if (rst && (kif.key_press || kif.key_release)) begin
      check("pulse_exclusive", 32'(kif.key_press & kif.key_release), 32'd0);
      mon_got = {kif.key_press, kif.key_code};
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event: got %0h want none", mon_got);
      end else begin
        mon_want = exp_q.pop_front();
        check("event", 32'(mon_got), 32'(mon_want));
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_accept(input int k);
    exp_q.push_back({1'b1, code_of(k)});
    keys[k] = 1'b1;
    wait_clk(HOLD);
    check("press_pending", 32'(exp_q.size()), 32'd0);
    check("held_code", 32'(kif.key_code), 32'(code_of(k)));
    check("held_valid", 32'(kif.key_valid), 32'd1);
    check("col_frozen", 32'(col_out), 32'(col_drive(k % 4)));
  endtask

  task automatic release_all();
    exp_q.push_back({1'b0, 8'hFF});
    keys = 16'd0;
    wait_clk(REL_WAIT);
    check("release_pending", 32'(exp_q.size()), 32'd0);
    check("idle_code", 32'(kif.key_code), 32'hFF);
    check("idle_valid", 32'(kif.key_valid), 32'd0);
  endtask

  task automatic expect_quiet(input string name, input logic [7:0] code);
    check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    check({name, "_code"}, 32'(kif.key_code), 32'(code));
  endtask

  initial begin
    int kind, k, k2, c, r1, r2;

    // Reset values.
    wait_clk(3);
    check("rst_col", 32'(col_out), 32'hE);
    check("rst_code", 32'(kif.key_code), 32'hFF);
    check("rst_valid", 32'(kif.key_valid), 32'd0);
    check("rst_press", 32'(kif.key_press), 32'd0);
    check("rst_release", 32'(kif.key_release), 32'd0);

    // Idle scan: column advances once per DIV clocks after reset release.
    rst = 1'b1;
    for (int n = 0; n < 60; n++) begin
      check("scan_col", 32'(col_out), 32'(col_drive((n / DIV) % 4)));
      wait_clk(1);
    end

    // Directed: tone c, then clean release.
    press_accept(0);
    release_all();

    // Directed: row1/col3 bounce lasting about one dwell.
    keys[7] = 1'b1;
    wait_clk(DIV);
    keys = 16'd0;
    wait_clk(3 * DIV);
    expect_quiet("bounce", 8'hFF);

    // Directed: release window too short, key comes back.
    press_accept(0);
    keys = 16'd0;
    wait_clk(15);
    keys[0] = 1'b1;
    wait_clk(3 * DIV);
    expect_quiet("short_release", code_of(0));
    release_all();

    // Directed: ghosting in column 2.
    keys[2] = 1'b1;
    keys[6] = 1'b1;
    wait_clk(HOLD);
    expect_quiet("ghost", 8'hFF);
    keys = 16'd0;
    wait_clk(2 * DIV);

    // Randomised scenarios.
    for (int s = 0; s < 40; s++) begin
      kind = $urandom_range(0, 4);
      k    = $urandom_range(0, 15);
      case (kind)
        0: begin
          press_accept(k);
          release_all();
        end
        1: begin
          keys[k] = 1'b1;
          wait_clk($urandom_range(1, 19));
          keys = 16'd0;
          wait_clk(2 * DIV);
          expect_quiet("glitch", 8'hFF);
        end
        2: begin
          c  = $urandom_range(0, 3);
          r1 = $urandom_range(0, 3);
          r2 = (r1 + $urandom_range(1, 3)) % 4;
          keys[r1*4+c] = 1'b1;
          keys[r2*4+c] = 1'b1;
          wait_clk(HOLD);
          expect_quiet("rand_ghost", 8'hFF);
          keys = 16'd0;
          wait_clk(2 * DIV);
        end
        3: begin
          press_accept(k);
          keys = 16'd0;
          wait_clk($urandom_range(1, 19));
          keys[k] = 1'b1;
          wait_clk(3 * DIV);
          expect_quiet("rand_rebounce", code_of(k));
          release_all();
        end
        default: begin
          press_accept(k);
          k2 = (k + $urandom_range(1, 15)) % 16;
          keys[k2] = 1'b1;
          wait_clk(HOLD);
          expect_quiet("second_key", code_of(k));
          release_all();
        end
      endcase
      wait_clk($urandom_range(0, 12));
    end

    // Reset while holding high C: outputs clear at once, no release pulse.
    press_accept(7);
    #3;
    rst = 1'b0;
    #1;
    check("arst_code", 32'(kif.key_code), 32'hFF);
    check("arst_valid", 32'(kif.key_valid), 32'd0);
    check("arst_release", 32'(kif.key_release), 32'd0);
    check("arst_col", 32'(col_out), 32'hE);
    keys = 16'd0;
    wait_clk(2);
    rst = 1'b1;
    wait_clk(HOLD);
    expect_quiet("post_reset", 8'hFF);

    check("final_pending", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
